counter: RTL and testbench

//  Free-running stage sequencer for the multi-cycle CPU control unit.

---
 rtl/counter.sv | 75 +++++++
 tb/tb_counter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Stage sequencer for the multi-cycle control unit: 0 idle, then 1..NUM_STAGES.
// Optional hold input enabled by defining COUNTER_STALL_EN.
module counter #(
    parameter int NUM_STAGES = 5,
    parameter int WIDTH      = 3,
    parameter int ICNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
`ifdef COUNTER_STALL_EN
    input  logic              stall,
`endif
    output logic [WIDTH-1:0]  out,
    output logic [NUM_STAGES:0] onehot_o,
    output logic              last_o,
    output logic [ICNT_W-1:0] icount_o
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(NUM_STAGES);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0]  out_q = '0;
    logic [WIDTH-1:0]  out_d;
    logic [ICNT_W-1:0] icnt_q = '0;
    logic [ICNT_W-1:0] icnt_d;
    logic              hold;

`ifdef COUNTER_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // Idle and unreachable codes both restart at stage 1 without counting.
    always_comb begin
        out_d  = out_q;
        icnt_d = icnt_q;
        if (!hold) begin
            unique case (1'b1)
                (out_q == LAST): begin
                    out_d  = ONE;
                    icnt_d = icnt_q + ICNT_W'(1);
                end
                (out_q == '0 || out_q > LAST): begin
                    out_d = ONE;
                end
                (out_q != '0 && out_q < LAST): begin
                    out_d = out_q + ONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            icnt_q <= '0;
        end else begin
            out_q  <= out_d;
            icnt_q <= icnt_d;
        end
    end

    always_comb begin
        onehot_o = '0;
        for (int k = 0; k <= NUM_STAGES; k++) begin
            onehot_o[k] = (out_q == k[WIDTH-1:0]);
        end
    end

    assign out      = out_q;
    assign last_o   = (out_q == LAST);
    assign icount_o = icnt_q;

endmodule

// File: tb/tb_counter.sv
// Directed checks for the stage sequencer, including a 4-bit count instance.
// Stall steps run only when COUNTER_STALL_EN is defined.
module tb_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  out;
    logic [5:0]  onehot;
    logic        last;
    logic [31:0] icount;
    logic [2:0]  out4;
    logic [5:0]  onehot4;
    logic        last4;
    logic [3:0]  icount4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter #(.NUM_STAGES(5), .WIDTH(3), .ICNT_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef COUNTER_STALL_EN
        .stall    (stall),
`endif
        .out      (out),
        .onehot_o (onehot),
        .last_o   (last),
        .icount_o (icount)
    );

    counter #(.NUM_STAGES(5), .WIDTH(3), .ICNT_W(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
`ifdef COUNTER_STALL_EN
        .stall    (stall),
`endif
        .out      (out4),
        .onehot_o (onehot4),
        .last_o   (last4),
        .icount_o (icount4)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, got, exp);
        end
    endtask

    // Full observation of the 32-bit instance at one stage.
    task automatic chk_all(input string tag,
                           input int eo,
                           input int ei);
        chk({tag, " out"}, 64'(out), 64'(eo));
        chk({tag, " onehot"}, 64'(onehot), 64'(6'b1 << eo));
        chk({tag, " last"}, 64'(last), 64'(eo == 5));
        chk({tag, " icount"}, 64'(icount), 64'(ei));
    endtask

    int seq1 [7] = '{1, 2, 3, 4, 5, 1, 2};
    int seq2 [9] = '{3, 4, 5, 1, 2, 3, 4, 5, 1};
    int ic2  [9] = '{1, 1, 1, 2, 2, 2, 2, 2, 3};

    initial begin
        #2;
        chk("powerup out", 64'(out), 64'd0);
        chk("powerup icount", 64'(icount), 64'd0);

        // reset held for two clocks
        @(negedge clk);
        chk_all("rst1", 0, 0);
        @(negedge clk);
        chk_all("rst2", 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk_all("seq1", seq1[i], (i >= 5) ? 1 : 0);
        end

        // three complete wraps since reset
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk_all("seq2", seq2[i], ic2[i]);
            chk("oh5_last", 64'(onehot[5]), 64'(last));
        end

        // reset in the middle of an instruction
        @(negedge clk);
        @(negedge clk);
        chk("pre_mid out", 64'(out), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        chk_all("mid_rst", 0, 0);
        chk("mid_rst icnt4", 64'(icount4), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk_all("mid_rel", 1, 0);

`ifdef COUNTER_STALL_EN
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk_all("pre_stall", 5, 0);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_all("stall", 5, 0);
        end
        stall = 1'b0;
        @(negedge clk);
        chk_all("stall_rel", 1, 1);
        stall = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        chk_all("rst_stall", 0, 0);
        stall = 1'b0;
`endif

        // 16 wraps on the 4-bit counter instance
        reset = 1'b1;
        @(negedge clk);
        chk_all("rst3", 0, 0);
        reset = 1'b0;
        for (int k = 1; k <= 81; k++) begin
            @(negedge clk);
            chk("wrap out4", 64'(out4), 64'((k - 1) % 5 + 1));
            chk("wrap out", 64'(out), 64'((k - 1) % 5 + 1));
            chk("wrap last4", 64'(last4), 64'((k - 1) % 5 == 4));
            chk("wrap oh4", 64'(onehot4),
                64'(6'b1 << ((k - 1) % 5 + 1)));
            if (k == 80) begin
                chk("icnt4_15", 64'(icount4), 64'd15);
            end
        end
        chk("icnt4_wrap", 64'(icount4), 64'd0);
        chk("icnt32_16", 64'(icount), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
